uart_hex_line_parser: RTL and testbench
=======================================

# uart_hex_line_parser

Parses ASCII hex response lines (ELM327-style, e.g. `41 0C 1A F8\r>`) from the UART receive FIFO into binary bytes. Sits directly downstream of the UART top: pops characters through its `rd_uart`/`rx_empty`/`r_data` FIFO port and emits a byte stream, a per-line completion strobe with byte count and error flag, and a prompt strobe for the command sequencer.

## Interface
- `DBIT`, 8: character width from the UART receive FIFO.
- `MAX_BYTES`, 16: maximum decoded bytes per line.
- `CNT_BITS`, 5: width of the byte counter; must hold `MAX_BYTES`.

- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `en`  in  1  when 0, no characters are popped; parser state is held.
- `rx_empty`  in  1  UART receive FIFO empty.
- `r_data`  in  DBIT  head of the UART receive FIFO, valid while `rx_empty`=0.
- `rd_uart`  out  1  pop strobe to the UART receive FIFO.
- `byte_data`  out  8  decoded byte.
- `byte_valid`  out  1  one-cycle strobe qualifying `byte_data`.
- `line_done`  out  1  one-cycle strobe marking the end of a non-empty line.
- `line_err`  out  1  qualified by `line_done`; the line was malformed.
- `byte_count`  out  CNT_BITS  bytes emitted for the line, qualified by `line_done`.
- `prompt_tick`  out  1  one-cycle strobe on the `>` prompt character.

## Operation
- Pop rule: `rd_uart = en & ~rx_empty & reset_n`, driven combinationally. One character is consumed per cycle, and the character is `r_data` in that cycle.
- The state machine has three states:
  - PAIR_HI: waiting for the first nibble of a pair.
  - PAIR_LO: holding the high nibble, waiting for the second nibble.
  - SKIP: discarding characters after an error until CR or `>`.
- Character classes: hex digit (0-9, A-F, a-f), SP (0x20), LF (0x0A), CR (0x0D), PROMPT (0x3E), and other.
- In PAIR_HI:
  - Hex: latch the nibble and go to PAIR_LO.
  - SP or LF: ignore.
  - CR: end the line.
  - Other: set `err` and go to SKIP.
- In PAIR_LO:
  - Hex: emit `{hi, lo}` on `byte_data` with `byte_valid`, increment count, and go to PAIR_HI.
  - SP, LF, or other: set `err` and go to SKIP.
  - CR: set `err` (odd nibble count) and end the line.
- In SKIP: ignore everything except CR and PROMPT.
- Overflow: a byte completing while count = `MAX_BYTES` is not emitted. Set `err` and go to SKIP.
- End of line (CR):
  - If count > 0 or `err` is set, pulse `line_done` with `line_err = err` and `byte_count = count`. A blank line (count = 0, no error) produces no strobe.
  - Then clear count and `err`, and go to PAIR_HI.
- PROMPT (any state):
  - Pulse `prompt_tick`.
  - If a partial line exists (count > 0, `err` set, or state ≠ PAIR_HI), also pulse `line_done` with `line_err = 1`.
  - Then clear count and `err`, and go to PAIR_HI.
- Input width: only `r_data[7:0]` is decoded. If `DBIT` = 7, the upper bit is treated as 0.

## Timing
- Latency: the character popped in cycle N produces `byte_valid`, `line_done`, and `prompt_tick` in cycle N+1. All three are registered.
- Back-to-back: a continuously non-empty FIFO yields one character per cycle. A byte is emitted at most every second cycle.
- `byte_count` and `line_err` are registered and change only in the cycle `line_done` is high. They hold their value otherwise.
- `en` falling: a character popped in the same cycle is still processed. No pops occur afterwards. Partial-line state is kept.
- Reset (`reset_n` = 0 at a `clk` edge), including mid-line:
  - State returns to PAIR_HI; count, `err`, and the nibble register are cleared.
  - All outputs go to 0: `byte_data` = 0, `byte_valid` = 0, `line_done` = 0, `line_err` = 0, `byte_count` = 0, `prompt_tick` = 0.
  - `rd_uart` is 0 during reset.

## Structure
- Shared package `uart_pkg` holds:
  - Character constants `CH_CR`, `CH_LF`, `CH_SP`, `CH_PROMPT`.
  - The parser state enum.
- One sub-module, `ascii_hex_decode`: purely combinational, 8-bit character in, `{is_hex, nibble[3:0]}` out.
- The rest is a single FSM plus the count, `err`, and nibble registers.

## Test plan
- Normal line: `41 0C 1A F8\r` → `byte_valid` ×4 carrying 0x41, 0x0C, 0x1A, 0xF8, then `line_done` with `byte_count` = 4 and `line_err` = 0.
- Non-hex text: `NO DATA\r>` → no `byte_valid`, then `line_done` with `line_err` = 1 and count 0. Next cycle `prompt_tick` (no second `line_done`).
- Odd nibbles and blank lines:
  - `410\r` → byte 0x41, then `line_done` with `line_err` = 1 and count 1.
  - `\r\n\r` → no strobes.
- Overflow: with `MAX_BYTES` = 4, `01 02 03 04 05 06\r` → four bytes, then `line_done` with `line_err` = 1 and count 4.
- Stall and reset:
  - Drop `en` mid-pair for 10 cycles → no pops, and the line completes correctly after resume.
  - Assert `reset_n` = 0 mid-line → all outputs 0. Then `7E\r` → byte 0x7E and count 1 with no error.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: character constants and parser state shared by the UART line parser.
package uart_pkg;

    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_PROMPT = 8'h3E;

    typedef enum logic [1:0] {
        PAIR_HI,
        PAIR_LO,
        SKIP
    } parse_state_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// ascii_hex_decode: combinational ASCII hex digit classifier and nibble decoder.
module ascii_hex_decode (
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nibble
);

    logic dig, up, low;

    assign dig    = ch >= 8'h30 && ch <= 8'h39;
    assign up     = ch >= 8'h41 && ch <= 8'h46;
    assign low    = ch >= 8'h61 && ch <= 8'h66;
    assign is_hex = dig | up | low;
    assign nibble = dig ? ch[3:0] : (up | low) ? ch[3:0] + 4'd9 : 4'd0;

endmodule

// File: rtl/uart_hex_line_parser.sv
// uart_hex_line_parser: turns ASCII hex response lines from the UART receive FIFO
// into a byte stream with per-line completion and prompt strobes.
module uart_hex_line_parser
    import uart_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int MAX_BYTES = 16,
    parameter int CNT_BITS  = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                rx_empty,
    input  logic [DBIT-1:0]     r_data,
    output logic                rd_uart,
    output logic [7:0]          byte_data,
    output logic                byte_valid,
    output logic                line_done,
    output logic                line_err,
    output logic [CNT_BITS-1:0] byte_count,
    output logic                prompt_tick
);

    parse_state_t        state, state_n;
    logic [CNT_BITS-1:0] count, count_n;
    logic                err, err_n;
    logic [3:0]          hi, hi_n;
    logic [7:0]          ch;
    logic                is_hex;
    logic [3:0]          nib;
    logic                emit, done, done_err, tick, end_line;

    assign rd_uart = en & ~rx_empty & reset_n;
    assign ch      = 8'(r_data);

    ascii_hex_decode u_dec (
        .ch     (ch),
        .is_hex (is_hex),
        .nibble (nib)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= PAIR_HI;
            count       <= '0;
            err         <= 1'b0;
            hi          <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            line_done   <= 1'b0;
            line_err    <= 1'b0;
            byte_count  <= '0;
            prompt_tick <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            err         <= err_n;
            hi          <= hi_n;
            byte_valid  <= emit;
            line_done   <= done;
            prompt_tick <= tick;
            if (emit)
                byte_data <= {hi, nib};
            if (done) begin
                line_err   <= done_err;
                byte_count <= count;
            end
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        err_n    = err;
        hi_n     = hi;
        emit     = 1'b0;
        done     = 1'b0;
        done_err = 1'b1;
        tick     = 1'b0;
        end_line = 1'b0;
        if (rd_uart) begin
            if (ch == CH_PROMPT) begin
                tick    = 1'b1;
                done    = count != '0 || err || state != PAIR_HI;
                count_n = '0;
                err_n   = 1'b0;
                state_n = PAIR_HI;
            end else begin
                case (state)
                    PAIR_HI: begin
                        if (is_hex) begin
                            hi_n    = nib;
                            state_n = PAIR_LO;
                        end else if (ch == CH_CR) begin
                            end_line = 1'b1;
                        end else if (ch != CH_SP && ch != CH_LF) begin
                            err_n   = 1'b1;
                            state_n = SKIP;
                        end
                    end
                    PAIR_LO: begin
                        // a full line drops the completing byte rather than wrapping the count
                        if (is_hex && count != CNT_BITS'(MAX_BYTES)) begin
                            emit    = 1'b1;
                            count_n = count + 1'b1;
                            state_n = PAIR_HI;
                        end else if (!is_hex && ch == CH_CR) begin
                            err_n    = 1'b1;
                            end_line = 1'b1;
                        end else begin
                            err_n   = 1'b1;
                            state_n = SKIP;
                        end
                    end
                    default: end_line = ch == CH_CR;
                endcase
                if (end_line) begin
                    done     = count_n != '0 || err_n;
                    done_err = err_n;
                    count_n  = '0;
                    err_n    = 1'b0;
                    state_n  = PAIR_HI;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_line_parser.sv
// tb_uart_hex_line_parser: scoreboard bench feeding hex lines through a modelled FIFO.
module tb_uart_hex_line_parser;

    localparam int EV_BYTE = 1, EV_LINE = 2, EV_PROMPT = 3;

    typedef struct {
        int k;
        int a;
        int b;
    } ev_t;

    logic       clk = 0;
    logic       reset_n = 0;
    logic       en = 1;
    logic       rx_empty = 1;
    logic [7:0] r_data = 0;
    logic       rd_uart;
    logic [7:0] byte_data;
    logic       byte_valid, line_done, line_err, prompt_tick;
    logic [4:0] byte_count;

    logic [7:0] fifo[$];
    ev_t        exp_q[$];
    int         total = 0, bad = 0;

    uart_hex_line_parser #(.DBIT(8), .MAX_BYTES(4), .CNT_BITS(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .rx_empty    (rx_empty),
        .r_data      (r_data),
        .rd_uart     (rd_uart),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .line_done   (line_done),
        .line_err    (line_err),
        .byte_count  (byte_count),
        .prompt_tick (prompt_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    task automatic expect_ev(input int k, input int a, input int b);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", k, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", k, e.k);
        chk("event_a", a, e.a);
        chk("event_b", b, e.b);
    endtask

    task automatic push_ev(input int k, input int a, input int b);
        exp_q.push_back('{k, a, b});
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++)
            fifo.push_back(s[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (fifo.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", fifo.size(), 0);
        repeat (3) @(posedge clk);
        chk("pending_events", exp_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"}, byte_data, 0);
        chk({tag, "_valid"}, byte_valid, 0);
        chk({tag, "_done"}, line_done, 0);
        chk({tag, "_err"}, line_err, 0);
        chk({tag, "_count"}, byte_count, 0);
        chk({tag, "_prompt"}, prompt_tick, 0);
        chk({tag, "_rd"}, rd_uart, 0);
    endtask

    always @(posedge clk)
        if (rd_uart && fifo.size() != 0)
            void'(fifo.pop_front());

    always @(negedge clk) begin
        rx_empty = fifo.size() == 0;
        r_data   = rx_empty ? 8'h00 : fifo[0];
        if (reset_n) begin
            if (byte_valid)
                expect_ev(EV_BYTE, byte_data, 0);
            if (line_done)
                expect_ev(EV_LINE, byte_count, line_err);
            if (prompt_tick)
                expect_ev(EV_PROMPT, 0, 0);
        end
    end

    initial begin
        int pops;
        send("A");
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        fifo.delete();
        @(negedge clk);
        reset_n = 1;

        push_ev(EV_BYTE, 8'h41, 0); push_ev(EV_BYTE, 8'h0C, 0);
        push_ev(EV_BYTE, 8'h1A, 0); push_ev(EV_BYTE, 8'hF8, 0);
        push_ev(EV_LINE, 4, 0);
        send("41 0C 1A F8\015");
        drain();

        push_ev(EV_LINE, 0, 1); push_ev(EV_PROMPT, 0, 0);
        send("NO DATA\015>");
        drain();

        push_ev(EV_BYTE, 8'h41, 0); push_ev(EV_LINE, 1, 1);
        send("410\015");
        drain();

        send("\015\012\015");
        drain();

        push_ev(EV_BYTE, 8'hFF, 0); push_ev(EV_BYTE, 8'h0A, 0); push_ev(EV_LINE, 2, 0);
        send("ff 0a\015");
        drain();

        for (int i = 1; i <= 4; i++)
            push_ev(EV_BYTE, i, 0);
        push_ev(EV_LINE, 4, 1);
        send("01 02 03 04 05 06\015");
        drain();

        push_ev(EV_BYTE, 8'hAB, 0); push_ev(EV_LINE, 1, 1); push_ev(EV_PROMPT, 0, 0);
        send("AB C>");
        drain();

        push_ev(EV_BYTE, 8'h12, 0);
        send("12 3");
        drain();
        @(negedge clk);
        en = 0;
        send("4\015");
        pops = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_uart)
                pops++;
        end
        chk("stall_pops", pops, 0);
        chk("stall_fifo", fifo.size(), 2);
        push_ev(EV_BYTE, 8'h34, 0); push_ev(EV_LINE, 2, 0);
        en = 1;
        drain();

        push_ev(EV_BYTE, 8'h55, 0);
        send("55 6");
        drain();
        @(negedge clk);
        reset_n = 0;
        send("7E\015");
        repeat (2) @(negedge clk);
        chk_outputs_zero("midreset");
        chk("midreset_fifo", fifo.size(), 3);
        reset_n = 1;
        push_ev(EV_BYTE, 8'h7E, 0); push_ev(EV_LINE, 1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
